// File: rtl/alu_exec_if.sv
// Bus between the decode/register-read stage and the execute stage.
// master = decode side (drives decode controls and operands),
// slave  = alu_exec (drives the registered results and the stall).
interface alu_exec_if #(
  parameter int REG_WIDTH = 16
);
  logic                 i_1_alu_in2_sel;
  logic [4:0]           i_5_alu_control;
  logic                 i_1_branch;
  logic                 i_1_mem_wr_en;
  logic                 i_1_mem2reg_sel;
  logic                 i_1_reg_wr_en;
  logic                 i_1_mem_addr_sel;
  logic [REG_WIDTH-1:0] i_R_rd1_data;
  logic [REG_WIDTH-1:0] i_R_rd2_data;
  logic [3:0]           i_4_reg_wr_addr;
  logic [REG_WIDTH-1:0] i_R_sign_imm;
  logic [REG_WIDTH-1:0] i_R_pcplus;

  logic [REG_WIDTH-1:0] or_R_alu_result;
  logic [REG_WIDTH-1:0] or_R_mem_wr_data;
  logic [3:0]           or_4_reg_wr_addr;
  logic                 or_1_mem_wr_en;
  logic                 or_1_mem2reg_sel;
  logic                 or_1_reg_wr_en;
  logic                 or_1_mem_addr_sel;
  logic                 or_1_branch_taken;
  logic [REG_WIDTH-1:0] or_R_branch_target;
  logic [3:0]           or_4_flags;
  logic                 o_1_stall;

  modport master (
    output i_1_alu_in2_sel, i_5_alu_control, i_1_branch, i_1_mem_wr_en,
           i_1_mem2reg_sel, i_1_reg_wr_en, i_1_mem_addr_sel, i_R_rd1_data,
           i_R_rd2_data, i_4_reg_wr_addr, i_R_sign_imm, i_R_pcplus,
    input  or_R_alu_result, or_R_mem_wr_data, or_4_reg_wr_addr, or_1_mem_wr_en,
           or_1_mem2reg_sel, or_1_reg_wr_en, or_1_mem_addr_sel, or_1_branch_taken,
           or_R_branch_target, or_4_flags, o_1_stall
  );

  modport slave (
    input  i_1_alu_in2_sel, i_5_alu_control, i_1_branch, i_1_mem_wr_en,
           i_1_mem2reg_sel, i_1_reg_wr_en, i_1_mem_addr_sel, i_R_rd1_data,
           i_R_rd2_data, i_4_reg_wr_addr, i_R_sign_imm, i_R_pcplus,
    output or_R_alu_result, or_R_mem_wr_data, or_4_reg_wr_addr, or_1_mem_wr_en,
           or_1_mem2reg_sel, or_1_reg_wr_en, or_1_mem_addr_sel, or_1_branch_taken,
           or_R_branch_target, or_4_flags, o_1_stall
  );
endinterface

// File: rtl/alu_exec.sv
// Execute stage of the 16-bit pipeline: ALU, flags {N,Z,C,V}, branch
// resolution, all registered for the memory stage.
// Optional feature macro EXEC_MUL_EN: builds a multi-cycle shift-add
// multiplier (opcode 01100) that stalls upstream while it runs. Without it
// opcode 01100 is an undefined code and o_1_stall is tied low.
module alu_exec #(
  parameter int REG_WIDTH = 16
) (
  input logic       clk,
  input logic       rst,
  alu_exec_if.slave bus
);
  localparam int SW = $clog2(REG_WIDTH);

  typedef enum logic [4:0] {
    OP_ADD   = 5'b00000,
    OP_SUB   = 5'b00001,
    OP_AND   = 5'b00010,
    OP_OR    = 5'b00011,
    OP_XOR   = 5'b00100,
    OP_NOT   = 5'b00101,
    OP_SHL   = 5'b00110,
    OP_SHR   = 5'b00111,
    OP_SRA   = 5'b01000,
    OP_PASSB = 5'b01001,
    OP_CMP   = 5'b01010,
    OP_INC   = 5'b01011,
    OP_MUL   = 5'b01100
  } op_e;

  logic [4:0]           op;
  logic [REG_WIDTH-1:0] opa, opb, alu_res;
  logic [SW-1:0]        shamt;
  logic [REG_WIDTH:0]   sum_w, dif_w, inc_w;
  logic                 alu_c, alu_v, alu_def;
  logic [3:0]           alu_flags;

  // Registered outputs
  logic [REG_WIDTH-1:0] result_q, result_d;
  logic [REG_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;
  logic [3:0]           reg_wr_addr_q, reg_wr_addr_d;
  logic                 mem_wr_en_q, mem_wr_en_d;
  logic                 mem2reg_q, mem2reg_d;
  logic                 reg_wr_en_q, reg_wr_en_d;
  logic                 mem_addr_sel_q, mem_addr_sel_d;
  logic                 taken_q, taken_d;
  logic [REG_WIDTH-1:0] target_q, target_d;
  logic [3:0]           flags_q, flags_d;

  logic                 stall;
  logic                 load_alu;

`ifdef EXEC_MUL_EN
  typedef enum logic {ST_IDLE, ST_BUSY} state_e;
  state_e               state_q, state_d;
  logic [SW-1:0]        count_q, count_d;
  logic [REG_WIDTH-1:0] mcand_q, mcand_d;
  logic [REG_WIDTH-1:0] mplier_q, mplier_d;
  logic [REG_WIDTH-1:0] prod_q, prod_d;
  logic [REG_WIDTH-1:0] prod_step;
  logic [REG_WIDTH-1:0] h_rd2_q, h_rd2_d;
  logic [REG_WIDTH-1:0] h_target_q, h_target_d;
  logic [3:0]           h_addr_q, h_addr_d;
  logic                 h_mem_wr_q, h_mem_wr_d;
  logic                 h_m2r_q, h_m2r_d;
  logic                 h_reg_wr_q, h_reg_wr_d;
  logic                 h_maddr_q, h_maddr_d;
  logic                 h_branch_q, h_branch_d;
`endif

  assign op = bus.i_5_alu_control;

  // Single-cycle ALU: result and flags for the current decode inputs
  always_comb begin
    opa     = bus.i_R_rd1_data;
    opb     = bus.i_1_alu_in2_sel ? bus.i_R_sign_imm : bus.i_R_rd2_data;
    shamt   = opb[SW-1:0];
    sum_w   = {1'b0, opa} + {1'b0, opb};
    // A + ~B + 1: carry-out is the "no borrow" flag
    dif_w   = {1'b0, opa} + {1'b0, ~opb} + {{REG_WIDTH{1'b0}}, 1'b1};
    inc_w   = {1'b0, opa} + {{REG_WIDTH{1'b0}}, 1'b1};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_def = 1'b1;
    case (op)
      OP_ADD: begin
        alu_res = sum_w[REG_WIDTH-1:0];
        alu_c   = sum_w[REG_WIDTH];
        alu_v   = (opa[REG_WIDTH-1] == opb[REG_WIDTH-1]) &&
                  (alu_res[REG_WIDTH-1] != opa[REG_WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        alu_res = dif_w[REG_WIDTH-1:0];
        alu_c   = dif_w[REG_WIDTH];
        alu_v   = (opa[REG_WIDTH-1] != opb[REG_WIDTH-1]) &&
                  (alu_res[REG_WIDTH-1] != opa[REG_WIDTH-1]);
      end
      OP_INC: begin
        alu_res = inc_w[REG_WIDTH-1:0];
        alu_c   = inc_w[REG_WIDTH];
        alu_v   = !opa[REG_WIDTH-1] && alu_res[REG_WIDTH-1];
      end
      OP_AND:   alu_res = opa & opb;
      OP_OR:    alu_res = opa | opb;
      OP_XOR:   alu_res = opa ^ opb;
      OP_NOT:   alu_res = ~opa;
      OP_SHL:   alu_res = opa << shamt;
      OP_SHR:   alu_res = opa >> shamt;
      OP_SRA:   alu_res = $signed(opa) >>> shamt;
      OP_PASSB: alu_res = opb;
      default:  alu_def = 1'b0;
    endcase
    alu_flags = alu_def ? {alu_res[REG_WIDTH-1], (alu_res == '0), alu_c, alu_v} : 4'b0000;
  end

  // Next-state: multiplier FSM (if built), ALU load path and stall bubble
  always_comb begin
    result_d       = result_q;
    mem_wr_data_d  = mem_wr_data_q;
    reg_wr_addr_d  = reg_wr_addr_q;
    mem_wr_en_d    = mem_wr_en_q;
    mem2reg_d      = mem2reg_q;
    reg_wr_en_d    = reg_wr_en_q;
    mem_addr_sel_d = mem_addr_sel_q;
    taken_d        = taken_q;
    target_d       = target_q;
    flags_d        = flags_q;
    stall          = 1'b0;
    load_alu       = 1'b0;
`ifdef EXEC_MUL_EN
    state_d    = state_q;
    count_d    = count_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    prod_d     = prod_q;
    h_rd2_d    = h_rd2_q;
    h_target_d = h_target_q;
    h_addr_d   = h_addr_q;
    h_mem_wr_d = h_mem_wr_q;
    h_m2r_d    = h_m2r_q;
    h_reg_wr_d = h_reg_wr_q;
    h_maddr_d  = h_maddr_q;
    h_branch_d = h_branch_q;
    prod_step  = prod_q + (mplier_q[0] ? mcand_q : '0);
    case (state_q)
      ST_IDLE: begin
        if (op == OP_MUL) begin
          mcand_d    = opa;
          mplier_d   = opb;
          prod_d     = '0;
          count_d    = '0;
          h_rd2_d    = bus.i_R_rd2_data;
          h_target_d = bus.i_R_pcplus + bus.i_R_sign_imm;
          h_addr_d   = bus.i_4_reg_wr_addr;
          h_mem_wr_d = bus.i_1_mem_wr_en;
          h_m2r_d    = bus.i_1_mem2reg_sel;
          h_reg_wr_d = bus.i_1_reg_wr_en;
          h_maddr_d  = bus.i_1_mem_addr_sel;
          h_branch_d = bus.i_1_branch;
          state_d    = ST_BUSY;
          stall      = 1'b1;
        end else begin
          load_alu = 1'b1;
        end
      end
      ST_BUSY: begin
        // One partial product per cycle; the last one is folded straight
        // into the output so the result lands without an extra cycle.
        prod_d   = prod_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + SW'(1);
        if (count_q == SW'(REG_WIDTH - 1)) begin
          result_d       = prod_step;
          flags_d        = {prod_step[REG_WIDTH-1], (prod_step == '0), 2'b00};
          mem_wr_data_d  = h_rd2_q;
          reg_wr_addr_d  = h_addr_q;
          mem_wr_en_d    = h_mem_wr_q;
          mem2reg_d      = h_m2r_q;
          reg_wr_en_d    = h_reg_wr_q;
          mem_addr_sel_d = h_maddr_q;
          taken_d        = h_branch_q && (prod_step == '0);
          target_d       = h_target_q;
          state_d        = ST_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`else
    load_alu = 1'b1;
`endif
    if (load_alu) begin
      result_d       = alu_res;
      flags_d        = alu_flags;
      mem_wr_data_d  = bus.i_R_rd2_data;
      reg_wr_addr_d  = bus.i_4_reg_wr_addr;
      mem_wr_en_d    = bus.i_1_mem_wr_en;
      mem2reg_d      = bus.i_1_mem2reg_sel;
      reg_wr_en_d    = bus.i_1_reg_wr_en && (op != OP_CMP);
      mem_addr_sel_d = bus.i_1_mem_addr_sel;
      taken_d        = bus.i_1_branch && alu_flags[2];
      target_d       = bus.i_R_pcplus + bus.i_R_sign_imm;
    end
    // Bubble: kill side effects, hold data and flags
    if (stall) begin
      reg_wr_en_d = 1'b0;
      mem_wr_en_d = 1'b0;
      taken_d     = 1'b0;
    end
  end

  // State and output registers, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q       <= '0;
      mem_wr_data_q  <= '0;
      reg_wr_addr_q  <= '0;
      mem_wr_en_q    <= 1'b0;
      mem2reg_q      <= 1'b0;
      reg_wr_en_q    <= 1'b0;
      mem_addr_sel_q <= 1'b0;
      taken_q        <= 1'b0;
      target_q       <= '0;
      flags_q        <= '0;
`ifdef EXEC_MUL_EN
      state_q    <= ST_IDLE;
      count_q    <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      prod_q     <= '0;
      h_rd2_q    <= '0;
      h_target_q <= '0;
      h_addr_q   <= '0;
      h_mem_wr_q <= 1'b0;
      h_m2r_q    <= 1'b0;
      h_reg_wr_q <= 1'b0;
      h_maddr_q  <= 1'b0;
      h_branch_q <= 1'b0;
`endif
    end else begin
      result_q       <= result_d;
      mem_wr_data_q  <= mem_wr_data_d;
      reg_wr_addr_q  <= reg_wr_addr_d;
      mem_wr_en_q    <= mem_wr_en_d;
      mem2reg_q      <= mem2reg_d;
      reg_wr_en_q    <= reg_wr_en_d;
      mem_addr_sel_q <= mem_addr_sel_d;
      taken_q        <= taken_d;
      target_q       <= target_d;
      flags_q        <= flags_d;
`ifdef EXEC_MUL_EN
      state_q    <= state_d;
      count_q    <= count_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      prod_q     <= prod_d;
      h_rd2_q    <= h_rd2_d;
      h_target_q <= h_target_d;
      h_addr_q   <= h_addr_d;
      h_mem_wr_q <= h_mem_wr_d;
      h_m2r_q    <= h_m2r_d;
      h_reg_wr_q <= h_reg_wr_d;
      h_maddr_q  <= h_maddr_d;
      h_branch_q <= h_branch_d;
`endif
    end
  end

  assign bus.or_R_alu_result    = result_q;
  assign bus.or_R_mem_wr_data   = mem_wr_data_q;
  assign bus.or_4_reg_wr_addr   = reg_wr_addr_q;
  assign bus.or_1_mem_wr_en     = mem_wr_en_q;
  assign bus.or_1_mem2reg_sel   = mem2reg_q;
  assign bus.or_1_reg_wr_en     = reg_wr_en_q;
  assign bus.or_1_mem_addr_sel  = mem_addr_sel_q;
  assign bus.or_1_branch_taken  = taken_q;
  assign bus.or_R_branch_target = target_q;
  assign bus.or_4_flags         = flags_q;
  assign bus.o_1_stall          = stall && !rst;

endmodule

// File: tb/tb_alu_exec.sv
// Directed, table-driven bench for alu_exec; multiplier sequences are
// exercised when EXEC_MUL_EN is defined, the undefined-opcode path otherwise.
module tb_alu_exec;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  alu_exec_if #(.REG_WIDTH(16)) bus ();

  alu_exec #(.REG_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic        sel;
    logic [15:0] a, rd2, imm, pc;
    logic        br, rw;
    logic [3:0]  addr;
    logic [15:0] exp_res;
    logic [3:0]  exp_fl;
    logic        exp_tk, exp_rw;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic sel, input logic [15:0] a,
                       input logic [15:0] rd2, input logic [15:0] imm, input logic [15:0] pc,
                       input logic br, input logic rw, input logic [3:0] addr);
    bus.i_5_alu_control  = op;
    bus.i_1_alu_in2_sel  = sel;
    bus.i_R_rd1_data     = a;
    bus.i_R_rd2_data     = rd2;
    bus.i_R_sign_imm     = imm;
    bus.i_R_pcplus       = pc;
    bus.i_1_branch       = br;
    bus.i_1_reg_wr_en    = rw;
    bus.i_4_reg_wr_addr  = addr;
    bus.i_1_mem_wr_en    = addr[0];
    bus.i_1_mem2reg_sel  = addr[1];
    bus.i_1_mem_addr_sel = addr[2];
  endtask

`ifdef EXEC_MUL_EN
  // MUL issued in the current cycle; upstream holds it while stalled
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input logic [3:0] addr,
                         input logic [15:0] exp_res, input logic [3:0] exp_fl);
    int stalls;
    stalls = 0;
    drive(5'b01100, 1'b0, a, b, 16'h0000, 16'h0000, 1'b0, 1'b1, addr);
    #1;
    for (int i = 0; i < 40; i++) begin
      if (!bus.o_1_stall) break;
      stalls++;
      tick();
      chk("mul_bubble", {29'd0, bus.or_1_reg_wr_en, bus.or_1_mem_wr_en, bus.or_1_branch_taken}, 0);
    end
    chk("mul_stall_cycles", stalls, 16);
    tick();
    chk("mul_result", bus.or_R_alu_result, exp_res);
    chk("mul_flags", bus.or_4_flags, exp_fl);
    chk("mul_dest", bus.or_4_reg_wr_addr, addr);
    chk("mul_reg_wr_en", bus.or_1_reg_wr_en, 1);
    chk("mul_wr_data", bus.or_R_mem_wr_data, b);
  endtask
`endif

  initial begin
    int seen;
    vec_t v;
    //              op     sel a        rd2      imm      pc       br   rw   addr  res      fl       tk   rw
    vecs.push_back('{5'h00,1'b0,16'h7FFF,16'h0001,16'h0000,16'h0000,1'b0,1'b1,4'h1,16'h8000,4'b1001,1'b0,1'b1});
    vecs.push_back('{5'h01,1'b0,16'h0005,16'h0005,16'h0004,16'h0010,1'b1,1'b1,4'h2,16'h0000,4'b0110,1'b1,1'b1});
    vecs.push_back('{5'h08,1'b1,16'h8010,16'h0000,16'h0004,16'h0020,1'b0,1'b1,4'h3,16'hF801,4'b1000,1'b0,1'b1});
    vecs.push_back('{5'h0A,1'b0,16'h0003,16'h0003,16'h0000,16'h0000,1'b0,1'b1,4'h4,16'h0000,4'b0110,1'b0,1'b0});
    vecs.push_back('{5'h02,1'b0,16'hF0F0,16'h0FF0,16'h0000,16'h0000,1'b0,1'b1,4'h5,16'h00F0,4'b0000,1'b0,1'b1});
    vecs.push_back('{5'h03,1'b0,16'hF000,16'h000F,16'h0000,16'h0000,1'b0,1'b1,4'h6,16'hF00F,4'b1000,1'b0,1'b1});
    vecs.push_back('{5'h04,1'b0,16'hAAAA,16'hAAAA,16'h0000,16'h0000,1'b0,1'b1,4'h7,16'h0000,4'b0100,1'b0,1'b1});
    vecs.push_back('{5'h05,1'b0,16'h00FF,16'h1234,16'h0000,16'h0000,1'b0,1'b1,4'h8,16'hFF00,4'b1000,1'b0,1'b1});
    vecs.push_back('{5'h06,1'b0,16'h0001,16'h0013,16'h0000,16'h0000,1'b0,1'b1,4'h9,16'h0008,4'b0000,1'b0,1'b1});
    vecs.push_back('{5'h06,1'b1,16'h0001,16'h0000,16'h000F,16'h0000,1'b0,1'b1,4'hA,16'h8000,4'b1000,1'b0,1'b1});
    vecs.push_back('{5'h07,1'b0,16'h8000,16'h000F,16'h0000,16'h0000,1'b0,1'b1,4'hB,16'h0001,4'b0000,1'b0,1'b1});
    vecs.push_back('{5'h08,1'b0,16'h7FF0,16'h0004,16'h0000,16'h0000,1'b0,1'b1,4'hC,16'h07FF,4'b0000,1'b0,1'b1});
    vecs.push_back('{5'h09,1'b1,16'h0000,16'hFFFF,16'h1234,16'h0000,1'b0,1'b1,4'hD,16'h1234,4'b0000,1'b0,1'b1});
    vecs.push_back('{5'h0B,1'b0,16'hFFFF,16'h0000,16'h0000,16'h0000,1'b0,1'b1,4'hE,16'h0000,4'b0110,1'b0,1'b1});
    vecs.push_back('{5'h0B,1'b0,16'h7FFF,16'h0000,16'h0000,16'h0000,1'b0,1'b1,4'hF,16'h8000,4'b1001,1'b0,1'b1});
    vecs.push_back('{5'h01,1'b0,16'h0003,16'h0005,16'h0000,16'h0000,1'b0,1'b1,4'h1,16'hFFFE,4'b1000,1'b0,1'b1});
    vecs.push_back('{5'h01,1'b0,16'h8000,16'h0001,16'h0000,16'h0000,1'b0,1'b1,4'h2,16'h7FFF,4'b0011,1'b0,1'b1});
    vecs.push_back('{5'h00,1'b0,16'h8000,16'h8000,16'h0000,16'h0000,1'b0,1'b1,4'h3,16'h0000,4'b0111,1'b0,1'b1});
    vecs.push_back('{5'h1F,1'b0,16'h0005,16'h0003,16'h0000,16'h0000,1'b1,1'b1,4'h4,16'h0000,4'b0000,1'b0,1'b1});
    vecs.push_back('{5'h01,1'b0,16'h0005,16'h0003,16'h0000,16'h0000,1'b1,1'b1,4'h5,16'h0002,4'b0010,1'b0,1'b1});
    vecs.push_back('{5'h00,1'b0,16'h0001,16'h0001,16'h0002,16'hFFFF,1'b0,1'b1,4'h6,16'h0002,4'b0000,1'b0,1'b1});

    // Reset with random inputs
    rst = 1'b1;
    drive(5'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
          16'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
    tick();
    tick();
    chk("rst_stall", bus.o_1_stall, 0);
    chk("rst_result", bus.or_R_alu_result, 0);
    chk("rst_flags", bus.or_4_flags, 0);
    chk("rst_ctrl", {bus.or_1_reg_wr_en, bus.or_1_mem_wr_en, bus.or_1_mem2reg_sel,
                     bus.or_1_mem_addr_sel, bus.or_1_branch_taken, bus.or_4_reg_wr_addr}, 0);
    chk("rst_data", {bus.or_R_mem_wr_data, bus.or_R_branch_target}, 0);
    drive(5'h1F, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 4'h0);
    rst = 1'b0;
    tick();

    // Single-cycle vectors
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.op, v.sel, v.a, v.rd2, v.imm, v.pc, v.br, v.rw, v.addr);
      #1;
      chk($sformatf("v%0d_stall", i), bus.o_1_stall, 0);
      tick();
      chk($sformatf("v%0d_result", i), bus.or_R_alu_result, v.exp_res);
      chk($sformatf("v%0d_flags", i), bus.or_4_flags, v.exp_fl);
      chk($sformatf("v%0d_taken", i), bus.or_1_branch_taken, v.exp_tk);
      chk($sformatf("v%0d_reg_wr_en", i), bus.or_1_reg_wr_en, v.exp_rw);
      chk($sformatf("v%0d_target", i), bus.or_R_branch_target, 16'(v.pc + v.imm));
      chk($sformatf("v%0d_wr_data", i), bus.or_R_mem_wr_data, v.rd2);
      chk($sformatf("v%0d_ctrl", i),
          {bus.or_4_reg_wr_addr, bus.or_1_mem_wr_en, bus.or_1_mem2reg_sel, bus.or_1_mem_addr_sel},
          {v.addr, v.addr[0], v.addr[1], v.addr[2]});
    end

`ifdef EXEC_MUL_EN
    run_mul(16'h0123, 16'h0010, 4'h7, 16'h1230, 4'b0000);
    drive(5'h1F, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 4'h0);
    tick();

    // Reset during the 8th BUSY cycle abandons the multiply
    drive(5'b01100, 1'b0, 16'h0123, 16'h0010, 16'h0, 16'h0, 1'b0, 1'b1, 4'h7);
    for (int i = 0; i < 8; i++) tick();
    chk("abort_busy_stall", bus.o_1_stall, 1);
    rst = 1'b1;
    #1;
    chk("abort_rst_stall", bus.o_1_stall, 0);
    tick();
    chk("abort_result", bus.or_R_alu_result, 0);
    chk("abort_ctrl", {bus.or_1_reg_wr_en, bus.or_4_reg_wr_addr, bus.or_4_flags}, 0);
    drive(5'h1F, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 4'h0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.or_R_alu_result == 16'h1230 || bus.o_1_stall) seen++;
    end
    chk("abort_no_result_no_stall", seen, 0);

    // Back-to-back multiplies
    run_mul(16'hFFFF, 16'h0002, 4'h3, 16'hFFFE, 4'b1000);
    run_mul(16'h0003, 16'h0003, 4'h5, 16'h0009, 4'b0000);
    drive(5'h1F, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 4'h0);
    tick();
`else
    // Opcode 01100 without the multiplier: undefined code, no stall
    drive(5'b01100, 1'b0, 16'h0003, 16'h0003, 16'h0000, 16'h0000, 1'b1, 1'b1, 4'h7);
    #1;
    chk("nomul_stall", bus.o_1_stall, 0);
    tick();
    chk("nomul_result", bus.or_R_alu_result, 0);
    chk("nomul_flags", bus.or_4_flags, 0);
    chk("nomul_taken", bus.or_1_branch_taken, 0);
    chk("nomul_dest", bus.or_4_reg_wr_addr, 4'h7);
    chk("nomul_stall_after", bus.o_1_stall, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
